ps2_key_rx: RTL and testbench

PS2_KEY_RX -- requirements
Module: ps2_key_rx

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_event_fifo.sv | 54 +++++
 rtl/ps2_key_rx.sv | 162 ++++++++++++++++
 tb/tb_ps2_key_rx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: decoder states, prefix bytes, event layout.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXT    = 2'd1,
    ST_BRK    = 2'd2,
    ST_EXTBRK = 2'd3
  } dec_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Event word is {ext, brk, code[7:0]}.
  localparam int EV_W = 10;

  function automatic logic odd_parity_ok(input logic [8:0] data_par);
    return ^data_par;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead event FIFO; a push into a full FIFO is accepted only with a same-cycle pop.
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clk_100MHz,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;
  logic             w_full, w_empty, w_pop, w_wr;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = i_pop && !w_empty;
  assign w_wr    = i_push && (!w_full || w_pop);
  assign o_ovf   = i_push && w_full && !w_pop;

  assign o_valid = !w_empty;
  assign o_data  = w_empty ? '0 : r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk_100MHz) begin
    if (w_wr) r_mem[r_wptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: filtered clock edge detect, 11-bit framing with timeout,
// prefix decoder and event FIFO with sticky error flags.
//   state     | meaning
//   ST_IDLE   | no prefix seen
//   ST_EXT    | E0 received
//   ST_BRK    | F0 received
//   ST_EXTBRK | E0 then F0 received
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_LEN    = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 200000,
  parameter int REPORT_MAKE = 1
) (
  input  logic                          clk_100MHz,
  input  logic                          reset,
  input  logic                          ps2clk,
  input  logic                          ps2data,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_break,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          err_parity,
  output logic                          err_frame,
  output logic                          err_ovf,
  input  logic                          err_clr
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_LEN-1:0] r_win;
  logic [1:0]          r_data_sync;
  logic [10:0]         r_shift;
  logic [3:0]          r_bitcnt;
  logic [TW-1:0]       r_to_cnt;
  logic                r_byte_vld;
  logic [7:0]          r_byte;
  dec_state_e          r_state, w_state_nxt;
  logic                r_push, w_emit;
  logic [EV_W-1:0]     r_ev, w_ev, w_head;
  logic                w_fall, w_frame_ok, w_timeout, w_set_parity, w_ovf;
  logic [10:0]         w_frame;
  logic                w_ext, w_brk;
  logic                r_err_parity, r_err_frame, r_err_ovf;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_win       <= '0;
      r_data_sync <= '0;
    end else begin
      r_win       <= {r_win[SYNC_LEN-2:0], ps2clk};
      r_data_sync <= {r_data_sync[0], ps2data};
    end
  end

  // Oldest half high, newest half low: a clean falling edge, glitches filtered out.
  assign w_fall       = (&r_win[SYNC_LEN-1:SYNC_LEN/2]) && !(|r_win[SYNC_LEN/2-1:0]);
  assign w_frame      = {r_data_sync[1], r_shift[10:1]};
  assign w_frame_ok   = !w_frame[0] && w_frame[10] && odd_parity_ok(w_frame[9:1]);
  assign w_set_parity = w_fall && (r_bitcnt == 4'd10) && !w_frame_ok;
  assign w_timeout    = !w_fall && (r_bitcnt != 4'd0) && (r_to_cnt == '0);

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_to_cnt   <= '0;
      r_byte_vld <= 1'b0;
      r_byte     <= '0;
    end else begin
      r_byte_vld <= 1'b0;
      if (w_fall) begin
        r_shift  <= w_frame;
        r_to_cnt <= TW'(TIMEOUT_CYC - 1);
        if (r_bitcnt == 4'd10) begin
          r_bitcnt   <= '0;
          r_byte_vld <= w_frame_ok;
          r_byte     <= w_frame[8:1];
        end else begin
          r_bitcnt <= r_bitcnt + 4'd1;
        end
      end else if (r_bitcnt != 4'd0) begin
        if (r_to_cnt == '0) r_bitcnt <= '0;
        else                r_to_cnt <= r_to_cnt - TW'(1);
      end else begin
        r_to_cnt <= TW'(TIMEOUT_CYC - 1);
      end
    end
  end

  assign w_ext = (r_state == ST_EXT) || (r_state == ST_EXTBRK);
  assign w_brk = (r_state == ST_BRK) || (r_state == ST_EXTBRK);

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_ev        = {w_ext, w_brk, r_byte};
    if (r_byte_vld) begin
      if (r_state == ST_IDLE && r_byte == PS2_EXT) begin
        w_state_nxt = ST_EXT;
      end else if (r_state == ST_IDLE && r_byte == PS2_BRK) begin
        w_state_nxt = ST_BRK;
      end else if (r_state == ST_EXT && r_byte == PS2_BRK) begin
        w_state_nxt = ST_EXTBRK;
      end else begin
        w_state_nxt = ST_IDLE;
        w_emit      = w_brk || (REPORT_MAKE != 0);
      end
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_push  <= 1'b0;
      r_ev    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_push  <= w_emit;
      r_ev    <= w_ev;
    end
  end

  ps2_event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .i_push     (r_push),
    .i_data     (r_ev),
    .i_pop      (ev_ready),
    .o_valid    (ev_valid),
    .o_data     (w_head),
    .o_count    (ev_count),
    .o_ovf      (w_ovf)
  );

  assign ev_ext   = w_head[9];
  assign ev_break = w_head[8];
  assign ev_code  = w_head[7:0];

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_err_parity <= 1'b0;
      r_err_frame  <= 1'b0;
      r_err_ovf    <= 1'b0;
    end else begin
      r_err_parity <= w_set_parity || (r_err_parity && !err_clr);
      r_err_frame  <= w_timeout    || (r_err_frame  && !err_clr);
      r_err_ovf    <= w_ovf        || (r_err_ovf    && !err_clr);
    end
  end

  assign err_parity = r_err_parity;
  assign err_frame  = r_err_frame;
  assign err_ovf    = r_err_ovf;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Scoreboard bench for ps2_key_rx: unit A (4-deep FIFO, make+break) and unit B (break only).
module tb_ps2_key_rx;
  localparam int TO = 1000;

  logic clk_100MHz = 1'b0;
  logic reset, ps2clk, ps2data, err_clr, r_sel_b;
  logic ev_ready_a;
  logic w_ps2clk_b;

  logic       ev_valid_a, ev_ext_a, ev_break_a, err_parity_a, err_frame_a, err_ovf_a;
  logic [7:0] ev_code_a;
  logic [2:0] ev_count_a;
  logic       ev_valid_b, ev_ext_b, ev_break_b, err_parity_b, err_frame_b, err_ovf_b;
  logic [7:0] ev_code_b;
  logic [3:0] ev_count_b;

  int n_tests = 0;
  int n_fail  = 0;
  logic [9:0] q_a[$];
  logic [9:0] q_b[$];
  logic [9:0] exp_a, exp_b;

  always #5 clk_100MHz = ~clk_100MHz;

  assign w_ps2clk_b = r_sel_b ? ps2clk : 1'b1;

  ps2_key_rx #(.SYNC_LEN(8), .FIFO_DEPTH(4), .TIMEOUT_CYC(TO), .REPORT_MAKE(1)) dut_a (
    .clk_100MHz (clk_100MHz), .reset (reset), .ps2clk (ps2clk), .ps2data (ps2data),
    .ev_valid (ev_valid_a), .ev_ready (ev_ready_a), .ev_code (ev_code_a),
    .ev_ext (ev_ext_a), .ev_break (ev_break_a), .ev_count (ev_count_a),
    .err_parity (err_parity_a), .err_frame (err_frame_a), .err_ovf (err_ovf_a),
    .err_clr (err_clr)
  );

  ps2_key_rx #(.SYNC_LEN(8), .FIFO_DEPTH(8), .TIMEOUT_CYC(TO), .REPORT_MAKE(0)) dut_b (
    .clk_100MHz (clk_100MHz), .reset (reset), .ps2clk (w_ps2clk_b), .ps2data (ps2data),
    .ev_valid (ev_valid_b), .ev_ready (1'b1), .ev_code (ev_code_b),
    .ev_ext (ev_ext_b), .ev_break (ev_break_b), .ev_count (ev_count_b),
    .err_parity (err_parity_b), .err_frame (err_frame_b), .err_ovf (err_ovf_b),
    .err_clr (err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_100MHz);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2data = f[i];
      tick(10);
      ps2clk = 1'b0;
      tick(20);
      ps2clk = 1'b1;
      tick(10);
    end
    ps2data = 1'b1;
    tick(30);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && (q_a.size() != 0 || q_b.size() != 0); i++) tick(1);
    tick(5);
    chk("drain_a", q_a.size(), 0);
    chk("drain_b", q_b.size(), 0);
    chk("idle_valid_a", ev_valid_a, 0);
    chk("idle_valid_b", ev_valid_b, 0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  // Pops happen on the next rising edge whenever valid and ready are both high here.
  always @(negedge clk_100MHz) begin
    if (!reset && ev_valid_a && ev_ready_a) begin
      chk("sb_a_nonempty", 32'(q_a.size() != 0), 1);
      if (q_a.size() != 0) begin
        exp_a = q_a.pop_front();
        chk("ev_a", {22'b0, ev_ext_a, ev_break_a, ev_code_a}, {22'b0, exp_a});
      end
    end
    if (!reset && ev_valid_b) begin
      chk("sb_b_nonempty", 32'(q_b.size() != 0), 1);
      if (q_b.size() != 0) begin
        exp_b = q_b.pop_front();
        chk("ev_b", {22'b0, ev_ext_b, ev_break_b, ev_code_b}, {22'b0, exp_b});
      end
    end
  end

  initial begin
    logic [7:0] codes [5];
    codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h2B};
    reset = 1'b1; ps2clk = 1'b1; ps2data = 1'b1; err_clr = 1'b0;
    ev_ready_a = 1'b1; r_sel_b = 1'b0;
    tick(3);
    chk("rst_valid", ev_valid_a, 0);
    chk("rst_code", ev_code_a, 0);
    chk("rst_ext", ev_ext_a, 0);
    chk("rst_break", ev_break_a, 0);
    chk("rst_count", ev_count_a, 0);
    chk("rst_errp", err_parity_a, 0);
    chk("rst_errf", err_frame_a, 0);
    chk("rst_erro", err_ovf_a, 0);
    reset = 1'b0;
    tick(20);

    // make/break on A, break-only on B
    r_sel_b = 1'b1;
    q_a.push_back({2'b00, 8'h1C}); q_a.push_back({2'b01, 8'h1C});
    q_b.push_back({2'b01, 8'h1C});
    send_frame(8'h1C, 0, 11); send_frame(8'hF0, 0, 11); send_frame(8'h1C, 0, 11);
    wait_drain();
    r_sel_b = 1'b0;

    // extended make and break
    q_a.push_back({2'b10, 8'h75}); q_a.push_back({2'b11, 8'h75});
    send_frame(8'hE0, 0, 11); send_frame(8'h75, 0, 11);
    send_frame(8'hE0, 0, 11); send_frame(8'hF0, 0, 11); send_frame(8'h75, 0, 11);
    wait_drain();

    // bad parity: no event, sticky flag, cleared by err_clr
    send_frame(8'h1C, 1, 11);
    tick(10);
    chk("par_err_set", err_parity_a, 1);
    chk("par_no_event", ev_count_a, 0);
    pulse_clr();
    chk("par_err_clr", err_parity_a, 0);

    // overflow with 4-deep FIFO
    ev_ready_a = 1'b0;
    for (int i = 0; i < 4; i++) q_a.push_back({2'b00, codes[i]});
    for (int i = 0; i < 5; i++) send_frame(codes[i], 0, 11);
    tick(10);
    chk("ovf_count", ev_count_a, 4);
    chk("ovf_flag", err_ovf_a, 1);
    ev_ready_a = 1'b1;
    wait_drain();
    chk("ovf_count_empty", ev_count_a, 0);
    pulse_clr();
    chk("ovf_clr", err_ovf_a, 0);

    // partial frame timeout
    send_frame(8'h2A, 0, 6);
    tick(TO - 100);
    chk("to_not_yet", err_frame_a, 0);
    tick(200);
    chk("to_err_set", err_frame_a, 1);
    pulse_clr();
    q_a.push_back({2'b00, 8'h2A});
    send_frame(8'h2A, 0, 11);
    wait_drain();

    // reset mid-frame
    send_frame(8'h1C, 0, 5);
    reset = 1'b1;
    tick(3);
    chk("mid_rst_valid", ev_valid_a, 0);
    chk("mid_rst_count", ev_count_a, 0);
    reset = 1'b0;
    tick(20);
    q_a.push_back({2'b00, 8'h1C});
    send_frame(8'h1C, 0, 11);
    wait_drain();
    chk("final_errp", err_parity_a, 0);
    chk("final_errf", err_frame_a, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
